button_input: RTL and testbench



---
 rtl/button_input_pkg.sv | 19 +
 rtl/button_input_debouncer.sv | 59 +++++
 rtl/button_input.sv | 110 +++++++++++
 tb/tb_button_input.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_input_pkg.sv
// button_input_pkg
//   Shared configuration for the button input peripheral: register offsets
//   (word index taken from address[3:2]), the enable switch for the block and
//   the address decode helper used by the bus logic.
package button_input_pkg;

    localparam bit BUTTON_ENABLE = 1'b1;

    localparam logic [1:0] BTN_STATE  = 2'd0;
    localparam logic [1:0] BTN_EDGE   = 2'd1;
    localparam logic [1:0] BTN_IRQ_EN = 2'd2;
    localparam logic [1:0] BTN_RAW    = 2'd3;

    // Only the word index is decoded; byte offset and upper bits are don't-care.
    function automatic logic [1:0] reg_sel(input logic [31:0] address);
        return address[3:2];
    endfunction

endpackage

// File: rtl/button_input_debouncer.sv
// button_input_debouncer
//   One input channel: 2-flop synchronizer, polarity correction, debounce
//   counter and the debounced level.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   button   in   asynchronous physical pin
//   sync     out  synchronized, polarity-corrected level (1 = pressed)
//   stable   out  debounced level
module button_input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button,
    output logic sync,
    output logic stable
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    // Synchronizer resets to the physical idle level so that no press is
    // seen right after reset release.
    localparam logic          IDLE_PIN = (ACTIVE_LOW != 0);
    localparam logic [CW-1:0] LAST     = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic          stable_q;
    logic [CW-1:0] count_q;

    assign sync   = (ACTIVE_LOW != 0) ? ~sync_q : sync_q;
    assign stable = stable_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q   <= IDLE_PIN;
            sync_q   <= IDLE_PIN;
            stable_q <= 1'b0;
            count_q  <= '0;
        end else begin
            meta_q <= button;
            sync_q <= meta_q;
            if (sync != stable_q) begin
                // The increment that would reach DEBOUNCE_CYCLES commits the
                // new level instead of being stored.
                if (count_q == LAST) begin
                    stable_q <= sync;
                    count_q  <= '0;
                end else begin
                    count_q <= count_q + 1'b1;
                end
            end else begin
                count_q <= '0;
            end
        end
    end

endmodule

// File: rtl/button_input.sv
// button_input
//   Memory-mapped push-button / switch input peripheral. Each pin is
//   synchronized and debounced; the debounced levels, sticky press flags,
//   interrupt mask and raw synchronized levels are readable on the bus.
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   read/write  in   bus strobes
//   address     in   byte address, word index in [3:2]
//   write_data  in   bus write data
//   read_data   out  selected register while read=1, else 0
//   response    out  read | write
//   buttons     in   physical pins (asynchronous)
//   irq         out  |(EDGE & IRQ_EN)
module button_input
    import button_input_pkg::*;
#(
    parameter int NUM_INPUTS      = 8,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           address,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data,
    output logic                  response,
    input  logic [NUM_INPUTS-1:0] buttons,
    output logic                  irq
);

    logic [NUM_INPUTS-1:0] sync_vec;
    logic [NUM_INPUTS-1:0] stable_vec;
    logic [NUM_INPUTS-1:0] stable_prev_q;
    logic [NUM_INPUTS-1:0] edge_q;
    logic [NUM_INPUTS-1:0] edge_next;
    logic [NUM_INPUTS-1:0] edge_view;
    logic [NUM_INPUTS-1:0] irq_en_q;
    logic [NUM_INPUTS-1:0] rise;
    logic [1:0]            sel;
    logic                  wr_edge;
    logic                  wr_irq_en;
    logic                  unused_wdata;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
        button_input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .button (buttons[i]),
            .sync   (sync_vec[i]),
            .stable (stable_vec[i])
        );
    end

    assign sel          = reg_sel(address);
    assign wr_edge      = BUTTON_ENABLE && write && (sel == BTN_EDGE);
    assign wr_irq_en    = BUTTON_ENABLE && write && (sel == BTN_IRQ_EN);
    assign unused_wdata = ^write_data;

    assign rise = stable_vec & ~stable_prev_q;

    // A press becomes visible (EDGE readback and irq) in the same cycle the
    // debounced level rises; edge_q holds it from the following cycle on.
    assign edge_view = edge_q | rise;

    always_comb begin
        edge_next = edge_q;
        if (wr_edge) begin
            edge_next = edge_next & ~write_data[NUM_INPUTS-1:0];
        end
        // Applied after the clear so a coincident press is never lost.
        edge_next = edge_next | rise;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_prev_q <= '0;
            edge_q        <= '0;
            irq_en_q      <= '0;
        end else begin
            stable_prev_q <= stable_vec;
            edge_q        <= edge_next;
            if (wr_irq_en) begin
                irq_en_q <= write_data[NUM_INPUTS-1:0];
            end
        end
    end

    always_comb begin
        read_data = '0;
        if (read && BUTTON_ENABLE) begin
            case (sel)
                BTN_STATE:  read_data = 32'(stable_vec);
                BTN_EDGE:   read_data = 32'(edge_view);
                BTN_IRQ_EN: read_data = 32'(irq_en_q);
                BTN_RAW:    read_data = 32'(sync_vec);
                default:    read_data = '0;
            endcase
        end
    end

    assign response = read | write;
    assign irq      = BUTTON_ENABLE && (|(edge_view & irq_en_q));

endmodule

// File: tb/tb_button_input.sv
module tb_button_input;
    import button_input_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        response;
    logic [7:0]  buttons;
    logic        irq;

    exp_t        sb[$];
    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] rd_val;
    logic [31:0] seen;

    button_input #(
        .NUM_INPUTS     (8),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW     (1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .read      (read),
        .write     (write),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .response  (response),
        .buttons   (buttons),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] observed);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", observed);
        end else begin
            e = sb.pop_front();
            vectors++;
            assert (observed === e.val)
            else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, observed, e.val);
            end
        end
    endtask

    task automatic rd(input logic [1:0] sel, output logic [31:0] d);
        address = {28'd0, sel, 2'b00};
        read    = 1'b1;
        #1;
        d    = read_data;
        read = 1'b0;
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        logic [31:0] d;
        push(tag, exp);
        rd(sel, d);
        check(d);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        push(tag, {31'd0, exp});
        check({31'd0, irq});
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] data);
        address    = {28'd0, sel, 2'b00};
        write_data = data;
        write      = 1'b1;
        tick();
        write      = 1'b0;
        write_data = '0;
    endtask

    initial begin
        reset_n    = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        write_data = '0;
        buttons    = 8'hFF;

        // Reset
        tick(); tick();
        chk_reg("rst_state",  BTN_STATE,  32'h0);
        chk_reg("rst_edge",   BTN_EDGE,   32'h0);
        chk_reg("rst_irq_en", BTN_IRQ_EN, 32'h0);
        chk_reg("rst_raw",    BTN_RAW,    32'h0);
        chk_irq("rst_irq", 1'b0);
        address = 32'h4;
        read    = 1'b1;
        #1;
        push("response_read", 32'h1);
        check({31'd0, response});
        read = 1'b0;
        #1;
        push("read_data_idle", 32'h0);
        check(read_data);
        push("response_idle", 32'h0);
        check({31'd0, response});
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk_reg("idle_state", BTN_STATE, 32'h0);
        chk_reg("idle_edge",  BTN_EDGE,  32'h0);

        // Press bit0
        buttons = 8'hFE;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 1) chk_reg("press_raw_t1", BTN_RAW, 32'h0);
            if (i == 2) chk_reg("press_raw_t2", BTN_RAW, 32'h1);
            if (i == 5) chk_reg("press_state_t5", BTN_STATE, 32'h0);
            if (i == 5) chk_reg("press_edge_t5", BTN_EDGE, 32'h0);
        end
        chk_reg("press_state_t6", BTN_STATE, 32'h1);
        chk_reg("press_edge_t6",  BTN_EDGE,  32'h1);
        chk_irq("press_irq_masked", 1'b0);

        // Writes to read-only register ignored
        wr(BTN_STATE, 32'hFFFF_FFFF);
        chk_reg("ro_state", BTN_STATE, 32'h1);

        // Bounce on bit1: never stable long enough
        seen = '0;
        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) buttons[1] = ~buttons[1];
            tick();
            rd(BTN_STATE, rd_val);
            seen = seen | rd_val;
            rd(BTN_EDGE, rd_val);
            seen = seen | rd_val;
        end
        buttons[1] = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        push("bounce_bit1_seen", 32'h0);
        check(seen & 32'h2);
        chk_reg("bounce_state", BTN_STATE, 32'h1);
        chk_reg("bounce_edge",  BTN_EDGE,  32'h1);

        // Interrupt
        wr(BTN_EDGE, 32'hFF);
        buttons = 8'hFF;
        for (int i = 0; i < 10; i++) tick();
        wr(BTN_IRQ_EN, 32'hFFFF_FF01);
        chk_reg("irq_en_readback", BTN_IRQ_EN, 32'h1);
        chk_reg("release_no_edge", BTN_EDGE,   32'h0);
        chk_irq("irq_idle", 1'b0);
        buttons = 8'hFE;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 5) chk_irq("irq_t5", 1'b0);
        end
        chk_irq("irq_t6", 1'b1);
        wr(BTN_EDGE, 32'h2);
        chk_irq("irq_after_w1c_other", 1'b1);
        wr(BTN_EDGE, 32'h1);
        chk_irq("irq_after_w1c", 1'b0);
        chk_reg("edge_after_w1c", BTN_EDGE, 32'h0);

        // Collision: W1C in the cycle bit2 rises
        buttons = 8'hFA;
        for (int i = 1; i <= 6; i++) tick();
        wr(BTN_EDGE, 32'h4);
        chk_reg("collision_edge",  BTN_EDGE,  32'h4);
        chk_reg("collision_state", BTN_STATE, 32'h5);
        chk_irq("collision_irq_masked", 1'b0);

        // Reset mid-debounce on bit3
        buttons = 8'hFF;
        for (int i = 0; i < 10; i++) tick();
        buttons = 8'hF7;
        for (int i = 0; i < 5; i++) tick();
        reset_n = 1'b0;
        tick(); tick();
        chk_reg("midrst_state_in_reset", BTN_STATE, 32'h0);
        reset_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 5) chk_reg("midrst_state_t5", BTN_STATE, 32'h0);
        end
        chk_reg("midrst_state_t6",  BTN_STATE,  32'h8);
        chk_reg("midrst_edge_t6",   BTN_EDGE,   32'h8);
        chk_reg("midrst_irq_en",    BTN_IRQ_EN, 32'h0);
        chk_irq("midrst_irq", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
